i2s_clk_gen: RTL and testbench



---
 rtl/i2s_clk_gen.sv | 110 +++++++++++
 tb/tb_i2s_clk_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clk_gen.sv
// Fractional-N I2S clock generator: a Bresenham accumulator toggles bclk num times per den
// enabled cycles; a slot counter derives bit_idx / lrclk / frame_start from falling bclk.
module i2s_clk_gen #(
    parameter int ACC_W     = 16,
    parameter int SLOT_BITS = 32,
    parameter int DEF_NUM   = 8,
    parameter int DEF_DEN   = 125
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [ACC_W-1:0]             cfg_num,
    input  logic [ACC_W-1:0]             cfg_den,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic                         cfg_err,
    output logic                         bclk,
    output logic                         bclk_rise,
    output logic                         bclk_fall,
    output logic                         lrclk,
    output logic                         frame_start,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx
);
    localparam int IDX_W = $clog2(SLOT_BITS);

    typedef struct packed {
        logic [ACC_W-1:0] num;
        logic [ACC_W-1:0] den;
    } ratio_t;

    logic [ACC_W-1:0] acc;
    ratio_t           cur;
    ratio_t           pend;
    logic             pend_vld;
    logic             pend_imm;
    logic [ACC_W:0]   sum;
    logic             tick;
    logic             wrap;
    logic             accept;
    logic             req_ok;

    assign sum       = {1'b0, acc} + {1'b0, cur.num};
    assign tick      = sum >= {1'b0, cur.den};
    assign wrap      = bit_idx == IDX_W'(SLOT_BITS - 1);
    assign cfg_ready = !pend_vld;
    assign accept    = cfg_valid && !pend_vld;
    assign req_ok    = (cfg_num != '0) && (cfg_num < cfg_den);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            cur.num     <= ACC_W'(DEF_NUM);
            cur.den     <= ACC_W'(DEF_DEN);
            pend        <= '0;
            pend_vld    <= 1'b0;
            pend_imm    <= 1'b0;
            cfg_err     <= 1'b0;
            bclk        <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            lrclk       <= 1'b0;
            frame_start <= 1'b0;
            bit_idx     <= '0;
        end else begin
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= 1'b0;
            // A ratio captured while stopped is loaded on the very next edge; that edge only
            // restarts the accumulator, so the bclk level is untouched and no glitch results.
            if (pend_imm) begin
                cur      <= pend;
                acc      <= '0;
                pend_vld <= 1'b0;
                pend_imm <= 1'b0;
            end else if (en) begin
                acc <= tick ? ACC_W'(sum - {1'b0, cur.den}) : sum[ACC_W-1:0];
                if (tick) begin
                    bclk      <= !bclk;
                    bclk_rise <= !bclk;
                    bclk_fall <= bclk;
                    if (bclk) begin
                        if (wrap) begin
                            bit_idx     <= '0;
                            lrclk       <= !lrclk;
                            frame_start <= lrclk;
                            if (lrclk && pend_vld) begin
                                cur      <= pend;
                                acc      <= '0;
                                pend_vld <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
            end
            if (accept) begin
                if (req_ok) begin
                    pend.num <= cfg_num;
                    pend.den <= cfg_den;
                    pend_vld <= 1'b1;
                    pend_imm <= !en;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_clk_gen.sv
// Bench for i2s_clk_gen: arithmetic reference model (toggles = floor(n*num/den)) checked
// every cycle, a handshake vector table, directed corner sequences and random stimulus.
module tb_i2s_clk_gen;
    localparam int ACC_W = 16;
    localparam int SLOT  = 32;

    logic             clk = 1'b0;
    logic             reset, en, cfg_valid;
    logic [ACC_W-1:0] cfg_num, cfg_den;
    logic             cfg_ready, cfg_err, bclk, bclk_rise, bclk_fall, lrclk, frame_start;
    logic [4:0]       bit_idx;

    i2s_clk_gen #(.ACC_W(ACC_W), .SLOT_BITS(SLOT), .DEF_NUM(8), .DEF_DEN(125)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .bclk(bclk),
        .bclk_rise(bclk_rise), .bclk_fall(bclk_fall), .lrclk(lrclk),
        .frame_start(frame_start), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: total toggles, toggles at epoch start, enabled cycles in epoch
    longint m_T, m_T0, m_n;
    int     m_num, m_den, m_pnum, m_pden;
    bit     m_pend, m_pimm, m_err, m_rise, m_fall, m_fs;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit v, input int nm, input int dn);
        bit     accept, ok;
        longint nt;
        accept = v && !m_pend;
        ok     = (nm != 0) && (nm < dn);
        m_rise = 0; m_fall = 0; m_fs = 0; m_err = 0;
        if (r) begin
            m_T = 0; m_T0 = 0; m_n = 0; m_num = 8; m_den = 125; m_pend = 0; m_pimm = 0;
            return;
        end
        if (m_pimm) begin
            m_T0 = m_T; m_n = 0; m_num = m_pnum; m_den = m_pden; m_pend = 0; m_pimm = 0;
        end else if (e) begin
            m_n++;
            nt = m_T0 + (m_n * m_num) / m_den;
            if (nt != m_T) begin
                m_rise = nt[0];
                m_fall = !nt[0];
                m_fs   = m_fall && ((nt / 2) % (2 * SLOT) == 0);
            end
            m_T = nt;
            if (m_fs && m_pend) begin
                m_T0 = m_T; m_n = 0; m_num = m_pnum; m_den = m_pden; m_pend = 0;
            end
        end
        if (accept) begin
            if (ok) begin
                m_pend = 1; m_pimm = !e; m_pnum = nm; m_pden = dn;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int nm, input int dn);
        reset = r; en = e; cfg_valid = v; cfg_num = ACC_W'(nm); cfg_den = ACC_W'(dn);
        @(posedge clk);
        model_edge(r, e, v, nm, dn);
        @(negedge clk);
        chk("bclk",        bclk,        m_T % 2);
        chk("bit_idx",     bit_idx,     (m_T / 2) % SLOT);
        chk("lrclk",       lrclk,       (m_T / (2 * SLOT)) % 2);
        chk("bclk_rise",   bclk_rise,   m_rise);
        chk("bclk_fall",   bclk_fall,   m_fall);
        chk("frame_start", frame_start, m_fs);
        chk("cfg_ready",   cfg_ready,   !m_pend);
        chk("cfg_err",     cfg_err,     m_err);
    endtask

    typedef struct {
        bit rst, en, vld;
        int num, den;
        bit exp_ready, exp_err;
    } vec_t;
    vec_t tbl[11];

    int  last, first_rise, bad, bad_lr, nrise, nfall, nfs, fs_t[$], nerr, k, rem, found;
    bit  prev_lr, h_bclk, h_lr;
    int  h_idx, lr_flips, falls;

    initial begin
        tbl[0]  = '{1, 1, 0,   0,   0, 1, 0};
        tbl[1]  = '{0, 1, 1,   0, 125, 1, 1};
        tbl[2]  = '{0, 1, 1, 125, 125, 1, 1};
        tbl[3]  = '{0, 1, 1, 130, 125, 1, 1};
        tbl[4]  = '{0, 1, 1,   0,   0, 1, 1};
        tbl[5]  = '{0, 1, 0,   0,   0, 1, 0};
        tbl[6]  = '{0, 0, 1,   5,   9, 0, 0};
        tbl[7]  = '{0, 0, 0,   0,   0, 1, 0};
        tbl[8]  = '{0, 1, 1,   1,   2, 0, 0};
        tbl[9]  = '{0, 1, 1,   0,   5, 0, 0};
        tbl[10] = '{1, 1, 1,   3,   7, 1, 0};

        // reset state
        step(1, 1, 1, 3, 7);
        chk("rst_bclk", bclk, 0); chk("rst_lrclk", lrclk, 0); chk("rst_idx", bit_idx, 0);
        chk("rst_ready", cfg_ready, 1); chk("rst_err", cfg_err, 0);

        // handshake table
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].num, tbl[i].den);
            chk($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].exp_err);
        end

        // defaults: 4000 clk -> 256 toggles, 15/16 half periods, frames every 2000 clk
        step(1, 1, 0, 0, 0);
        last = 0; first_rise = 0; bad = 0; bad_lr = 0; nrise = 0; nfall = 0; nfs = 0;
        prev_lr = 0; lr_flips = 0; falls = 0; fs_t.delete();
        for (int i = 1; i <= 4000; i++) begin
            step(0, 1, 0, 0, 0);
            if (bclk_rise || bclk_fall) begin
                if (last > 0 && ((i - last) < 15 || (i - last) > 16)) bad++;
                if (bclk_rise && first_rise == 0) first_rise = i;
                last = i;
            end
            if (bclk_rise) nrise++;
            if (bclk_fall) begin nfall++; falls++; end
            if (bit_idx != 5'(falls % SLOT)) bad++;
            if (lrclk != prev_lr) begin lr_flips++; if (!bclk_fall) bad_lr++; end
            prev_lr = lrclk;
            if (frame_start) begin nfs++; fs_t.push_back(i); end
        end
        chk("def_rise", nrise, 128); chk("def_fall", nfall, 128);
        chk("def_halfper_bad", bad, 0); chk("def_first_rise", first_rise, 16);
        chk("def_lr_outside_fall", bad_lr, 0); chk("def_lr_flips", lr_flips, 4);
        chk("def_nfs", nfs, 2);
        if (fs_t.size() == 2) begin chk("def_fs0", fs_t[0], 2000); chk("def_fs1", fs_t[1], 4000); end

        // mid-frame reprogram to 1/25 at bit_idx 10 of the left slot
        step(1, 1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(0, 1, 0, 0, 0);
            if (bit_idx == 10 && !lrclk) found = 1;
        end
        chk("mid_found", found, 1);
        step(0, 1, 1, 1, 25);
        chk("mid_ready_low", cfg_ready, 0);
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step(0, 1, 0, 0, 0);
            if (frame_start) found = 1;
        end
        chk("mid_fs_seen", found, 1);
        chk("mid_ready_back", cfg_ready, 1);
        last = 0; bad = 0; k = 0;
        for (int i = 1; i <= 300; i++) begin
            step(0, 1, 0, 0, 0);
            if (bclk_rise || bclk_fall) begin
                if (i - last != 25) bad++;
                last = i; k++;
            end
        end
        chk("mid_halfper25_bad", bad, 0); chk("mid_toggles", k, 12);

        // invalid requests leave the default ratio intact
        step(1, 1, 0, 0, 0);
        nerr = 0; k = 0;
        for (int i = 1; i <= 4000; i++) begin
            if (i == 1)      step(0, 1, 1, 0, 125);
            else if (i == 3) step(0, 1, 1, 125, 125);
            else if (i == 5) step(0, 1, 1, 130, 125);
            else             step(0, 1, 0, 0, 0);
            if (cfg_err) nerr++;
            if (bclk_rise || bclk_fall) k++;
        end
        chk("err_pulses", nerr, 3); chk("err_toggles", k, 256);

        // en low for 37 cycles in the middle of a half-period
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0);
        rem = 1;
        while (((40 + rem) * 8) / 125 == (40 * 8) / 125) rem++;
        h_bclk = bclk; h_lr = lrclk; h_idx = bit_idx; bad = 0;
        for (int i = 0; i < 37; i++) begin
            step(0, 0, 0, 0, 0);
            if (bclk != h_bclk || lrclk != h_lr || bit_idx != 5'(h_idx)) bad++;
            if (bclk_rise || bclk_fall || frame_start) bad++;
        end
        chk("hold_bad", bad, 0);
        found = 0; k = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step(0, 1, 0, 0, 0);
            if (bclk_rise || bclk_fall) begin found = 1; k = i; end
        end
        chk("hold_remaining", k, rem);

        // reset while a ratio is pending and bclk is high
        step(1, 1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, 1, 0, 0, 0);
            if (bclk) found = 1;
        end
        chk("pr_bclk_high", found, 1);
        step(0, 1, 1, 1, 25);
        chk("pr_pending", cfg_ready, 0); chk("pr_bclk_still_high", bclk, 1);
        step(1, 1, 0, 0, 0);
        chk("pr_bclk", bclk, 0); chk("pr_lrclk", lrclk, 0);
        chk("pr_idx", bit_idx, 0); chk("pr_ready", cfg_ready, 1);
        k = 0;
        for (int i = 0; i < 4000; i++) begin
            step(0, 1, 0, 0, 0);
            if (bclk_rise || bclk_fall) k++;
        end
        chk("pr_toggles", k, 256);

        // randomized traffic against the model
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 999) < 3, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 42), $urandom_range(2, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
